// File: rtl/aha_cm3_pmu_pkg.sv
// Shared types for the Cortex-M3 power-management controller: the FSM state
// encoding, the width of the exported state, and the per-state decode of the
// three power-control outputs.
package aha_cm3_pmu_pkg;

  localparam int PMU_STATE_W = 3;

  typedef enum logic [PMU_STATE_W-1:0] {
    ST_RUN      = 3'd0,
    ST_WIC_REQ  = 3'd1,
    ST_HOLD_REQ = 3'd2,
    ST_GATED    = 3'd3,
    ST_WAKE     = 3'd4
  } pmu_state_e;

  // Power-control outputs driven towards the CPU integration block.
  typedef struct packed {
    logic wic_en_req;
    logic sleephold_req_n;
    logic gclk_en;
  } pmu_ctl_t;

  // Outputs while running: clock on, no hold, WIC idle.
  localparam pmu_ctl_t CTL_RUN = '{wic_en_req: 1'b0, sleephold_req_n: 1'b1, gclk_en: 1'b1};

  // Output decode for each state. The WIC request stays up from WIC_REQ until
  // the FSM is back in RUN so the WIC handshake remains four-phase.
  function automatic pmu_ctl_t state_ctl(input pmu_state_e s);
    pmu_ctl_t c;
    c = CTL_RUN;
    case (s)
      ST_WIC_REQ:  c = '{wic_en_req: 1'b1, sleephold_req_n: 1'b1, gclk_en: 1'b1};
      ST_HOLD_REQ: c = '{wic_en_req: 1'b1, sleephold_req_n: 1'b0, gclk_en: 1'b1};
      ST_GATED:    c = '{wic_en_req: 1'b1, sleephold_req_n: 1'b0, gclk_en: 1'b0};
      ST_WAKE:     c = '{wic_en_req: 1'b1, sleephold_req_n: 1'b0, gclk_en: 1'b1};
      default:     c = CTL_RUN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aha_pmu_ack_delay.sv
// One four-phase delayed acknowledge: ACK rises DLY+1 edges after REQ is
// first sampled high and falls on the edge after REQ is sampled low. A request
// withdrawn before ACK rises loses its progress.
module aha_pmu_ack_delay #(
  parameter int DLY = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic REQ,
  output logic ACK
);

  localparam int CNT_W = $clog2(DLY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DLY);

  logic [CNT_W-1:0] cnt;

  // Count consecutive high-REQ edges; the counter passes DLY-1 and parks at
  // DLY, and ACK is raised on the edge after it parks. The count never wraps.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ACK <= 1'b0;
    end else if (!REQ) begin
      cnt <= '0;
      ACK <= 1'b0;
    end else if (!ACK) begin
      if (cnt == CNT_MAX) ACK <= 1'b1;
      else                cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aha_cm3_pmu.sv
// Power-management controller for the Cortex-M3 code-region integration.
// Sequences deep-sleep entry/exit through the WIC and sleep-hold handshakes,
// drives the CPU_GCLK gate enable and answers the debug power/reset requests.
// Clocked only by the free-running CPU_FCLK so it stays live while gated.
module aha_cm3_pmu
  import aha_cm3_pmu_pkg::*;
#(
  parameter int WIC_TIMEOUT = 64,
  parameter int WAKE_DLY    = 4,
  parameter int PWRUP_DLY   = 8
) (
  input  logic                   CPU_FCLK,
  input  logic                   CPU_PORESETn,
  input  logic                   SLEEP,
  input  logic                   SLEEPDEEP,
  input  logic                   SLEEPHOLDACKn,
  input  logic                   PMU_WIC_EN_ACK,
  input  logic                   PMU_WAKEUP,
  input  logic                   DBGPWRUPREQ,
  input  logic                   DBGSYSPWRUPREQ,
  input  logic                   DBGRSTREQ,
  output logic                   PMU_WIC_EN_REQ,
  output logic                   SLEEPHOLDREQn,
  output logic                   CPU_GCLK_EN,
  output logic                   DBGPWRUPACK,
  output logic                   DBGSYSPWRUPACK,
  output logic                   DBGRSTACK,
  output logic [PMU_STATE_W-1:0] PMU_STATE
);

  localparam int WIC_W  = $clog2(WIC_TIMEOUT + 1);
  localparam int WAKE_W = $clog2(WAKE_DLY + 1);

  localparam logic [WIC_W-1:0]  WIC_LAST  = WIC_W'(WIC_TIMEOUT - 1);
  localparam logic [WIC_W-1:0]  WIC_MAX   = WIC_W'(WIC_TIMEOUT);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_DLY - 1);
  localparam logic [WAKE_W-1:0] WAKE_MAX  = WAKE_W'(WAKE_DLY);

  pmu_state_e        state;
  pmu_state_e        next_state;
  pmu_ctl_t          ctl_q;
  logic [WIC_W-1:0]  wic_cnt;
  logic [WAKE_W-1:0] wake_cnt;

  // Next-state decode for the deep-sleep sequencer.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        // ACK must be low again before a new entry: four-phase WIC handshake.
        if (SLEEP && SLEEPDEEP && !DBGSYSPWRUPREQ && !PMU_WIC_EN_ACK)
          next_state = ST_WIC_REQ;
      end
      ST_WIC_REQ: begin
        if (PMU_WIC_EN_ACK)                   next_state = ST_HOLD_REQ;
        else if (!SLEEP || wic_cnt >= WIC_LAST) next_state = ST_RUN;
      end
      ST_HOLD_REQ: begin
        if (!SLEEPHOLDACKn)                 next_state = ST_GATED;
        else if (!SLEEP || DBGSYSPWRUPREQ) next_state = ST_WAKE;
      end
      ST_GATED: begin
        if (PMU_WAKEUP || DBGSYSPWRUPREQ) next_state = ST_WAKE;
      end
      ST_WAKE: begin
        if (wake_cnt >= WAKE_LAST) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  // State register plus registered outputs decoded from the upcoming state,
  // so every control output changes on the same edge as the state.
  always_ff @(posedge CPU_FCLK or negedge CPU_PORESETn) begin
    if (!CPU_PORESETn) begin
      state <= ST_RUN;
      ctl_q <= CTL_RUN;
    end else begin
      state <= next_state;
      ctl_q <= state_ctl(next_state);
    end
  end

  // WIC acknowledge timeout: counts cycles spent in WIC_REQ, zero elsewhere.
  always_ff @(posedge CPU_FCLK or negedge CPU_PORESETn) begin
    if (!CPU_PORESETn)              wic_cnt <= '0;
    else if (state != ST_WIC_REQ)   wic_cnt <= '0;
    else if (wic_cnt != WIC_MAX)    wic_cnt <= wic_cnt + 1'b1;
  end

  // Wake delay: counts cycles spent in WAKE with the clock running but the
  // hold still asserted, zero elsewhere.
  always_ff @(posedge CPU_FCLK or negedge CPU_PORESETn) begin
    if (!CPU_PORESETn)           wake_cnt <= '0;
    else if (state != ST_WAKE)   wake_cnt <= '0;
    else if (wake_cnt != WAKE_MAX) wake_cnt <= wake_cnt + 1'b1;
  end

  assign PMU_WIC_EN_REQ = ctl_q.wic_en_req;
  assign SLEEPHOLDREQn  = ctl_q.sleephold_req_n;
  assign CPU_GCLK_EN    = ctl_q.gclk_en;
  assign PMU_STATE      = state;

  aha_pmu_ack_delay #(.DLY(PWRUP_DLY)) u_dbg_pwrup_ack (
    .clk   (CPU_FCLK),
    .rst_n (CPU_PORESETn),
    .REQ   (DBGPWRUPREQ),
    .ACK   (DBGPWRUPACK)
  );

  aha_pmu_ack_delay #(.DLY(PWRUP_DLY)) u_dbg_syspwrup_ack (
    .clk   (CPU_FCLK),
    .rst_n (CPU_PORESETn),
    .REQ   (DBGSYSPWRUPREQ),
    .ACK   (DBGSYSPWRUPACK)
  );

  aha_pmu_ack_delay #(.DLY(PWRUP_DLY)) u_dbg_rst_ack (
    .clk   (CPU_FCLK),
    .rst_n (CPU_PORESETn),
    .REQ   (DBGRSTREQ),
    .ACK   (DBGRSTACK)
  );

endmodule
